// File: rtl/display_pkg.sv
// Shared constants, FSM state type and round-robin helper for the display source arbiter.
package display_pkg;

  localparam logic [1:0] SRC_SW     = 2'd0;
  localparam logic [1:0] SRC_KEYCNT = 2'd1;
  localparam logic [1:0] SRC_CLKCNT = 2'd2;
  localparam logic [1:0] SRC_CONST  = 2'd3;

  localparam logic [3:0] IDLE_BLANK = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // First requesting index searching cur+1, cur+2, cur+3, cur (mod 4); cur if none.
  function automatic logic [1:0] rr_next(input logic [3:0] req, input logic [1:0] cur);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = cur;
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces an active-low push-button, emitting one pulse per press.
// After reset the button must be seen released for a full debounce period before presses count.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic pressed_pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          armed_q, armed_d;
  logic [1:0]    live_q, live_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          cnt_hit;

  assign cnt_hit       = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign pressed_pulse = pulse_q;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    live_d  = {live_q[0], 1'b1};
    level_d = level_q;
    armed_d = armed_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (!armed_q) begin
      // live_q marks the synchroniser as holding real samples rather than reset values
      if (live_q[1] && sync2_q) begin
        if (cnt_hit) armed_d = 1'b1;
        else         cnt_d   = cnt_q + CW'(1);
      end
    end else if (sync2_q != level_q) begin
      if (cnt_hit) begin
        level_d = sync2_q;
        pulse_d = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      live_q  <= 2'b00;
      level_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      live_q  <= live_d;
      level_q <= level_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: rtl/display_source_arbiter.sv
// Round-robin arbiter choosing which of four nibble sources drives the seven-segment display.
// Define AUTO_SCAN_EN to honour mode_auto and build the timed dwell rotation.
module display_source_arbiter
  import display_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       step_n,
  input  logic       mode_auto,
  input  logic [3:0] req,
  input  logic [3:0] src0,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic [3:0] src3,
  output logic [1:0] sel,
  output logic [3:0] disp_data,
  output logic       disp_valid,
  output logic       step_pulse
);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] disp_data_q, disp_data_d;
  logic       disp_valid_q, disp_valid_d;
  logic       pulse;
  logic       grant;
  logic       advance;
  logic       dwell_exp;
  logic [1:0] rr_sel;
  logic [3:0] src_sel;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .key_n         (step_n),
    .pressed_pulse (pulse)
  );

  assign step_pulse = pulse;
  assign sel        = sel_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;

`ifdef AUTO_SCAN_EN
  localparam int unsigned DW = $clog2(DWELL_CYCLES);

  logic [DW-1:0] dwell_q, dwell_d;
  logic          mode_q;

  assign dwell_exp = mode_auto && (dwell_q == DW'(DWELL_CYCLES - 1));

  // Dwell runs only while showing in auto mode; any grant or mode flip restarts it.
  always_comb begin
    dwell_d = '0;
    if ((state_q == SHOW) && mode_auto && (mode_auto == mode_q) && !grant)
      dwell_d = dwell_q + DW'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      mode_q  <= mode_auto;
    end
  end
`else
  logic unused_cfg;
  assign dwell_exp  = 1'b0;
  assign unused_cfg = ^{mode_auto, 32'(DWELL_CYCLES)};
`endif

  always_comb begin
    src_sel = src0;
    case (sel_q)
      SRC_SW:     src_sel = src0;
      SRC_KEYCNT: src_sel = src1;
      SRC_CLKCNT: src_sel = src2;
      SRC_CONST:  src_sel = src3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    grant        = 1'b0;
    rr_sel       = rr_next(req, sel_q);
    // A press and a dwell expiry on the same clock still collapse into one advance
    advance      = pulse || dwell_exp || !req[sel_q];
    case (state_q)
      IDLE: begin
        if (req != 4'd0) begin
          state_d = SHOW;
          sel_d   = rr_sel;
          grant   = 1'b1;
        end
      end
      SHOW: begin
        if (advance) begin
          if (req == 4'd0) begin
            state_d = IDLE;
          end else begin
            sel_d = rr_sel;
            grant = 1'b1;
          end
        end
      end
    endcase
    disp_valid_d = (state_q == SHOW);
    disp_data_d  = (state_q == SHOW) ? src_sel : IDLE_BLANK;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 2'd0;
      disp_data_q  <= 4'd0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
    end
  end

endmodule
